sync_fifo_core: RTL and testbench

- Synchronous single-clock FIFO; the responder on fifo_intf, i.e. the DUT side driven by the FIFO stimulus/test module.
- Stores DATA_WIDTH-bit words and returns them in order with a registered read.
- Reports full/empty, almost thresholds, occupancy count, and overflow/underflow error pulses for the scoreboard.

---
 rtl/fifo_common_pkg.sv | 18 +
 rtl/fifo_mem_2p.sv | 43 ++++
 rtl/sync_fifo_core.sv | 130 +++++++++++++
 tb/tb_sync_fifo_core.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fifo_common_pkg.sv
// Shared FIFO definitions: default geometry and the status bundle that the
// FIFO core and its scoreboard both use.
package fifo_common_pkg;

    localparam int FIFO_DEF_DATA_WIDTH = 8;
    localparam int FIFO_DEF_DEPTH      = 8;

    // Flag bundle: level decodes plus the registered error pulses.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage : fifo_common_pkg

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_WIDTH register array with one synchronous write port and one
// synchronous read port. The read port has a registered output that holds
// its value between reads. Only that output register is reset; the array
// contents are not.
module fifo_mem_2p #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Storage write. There is no reset, so stale contents survive reset but
    // can never be read because the pointers restart together.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read. A same-edge write to the read address returns the old
    // word, which is the correct one when the FIFO is full.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : fifo_mem_2p

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO with a registered read. The state is just the pointers
// and the occupancy count. All level flags are decoded from the registered
// count. overflow and underflow report rejected requests one cycle later.
module sync_fifo_core
    import fifo_common_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEF_DEPTH,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_write_enable,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic                  i_read_enable,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_read_valid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [ADDR_W:0]       o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam logic [ADDR_W:0]   CNT_DEPTH = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_AF    = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_AE    = AE_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_ONE   = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE   = 1;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_read_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_rd_ok;
    logic              w_wr_ok;
    fifo_status_t      w_status;

    // Accept/reject decisions use only this cycle's registered state. A write
    // into a full FIFO is allowed when a read frees a slot on the same edge.
    // A read on an empty FIFO is never bypassed from the write.
    always_comb begin
        w_rd_ok = i_read_enable && !w_status.empty;
        w_wr_ok = i_write_enable && (!w_status.full || w_rd_ok);
    end

    // Pointer advance. Power-of-two depth makes the natural wrap modulo DEPTH.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Occupancy. A simultaneous accepted read and write leave it unchanged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else begin
            unique case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // One-cycle event pulses: read data landed, or a request was refused.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_read_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_read_valid <= w_rd_ok;
            r_overflow   <= i_write_enable && !w_wr_ok;
            r_underflow  <= i_read_enable && !w_rd_ok;
        end
    end

    // Level flags come from the registered count, so each flag changes on the
    // cycle after the edge that caused the change.
    always_comb begin
        w_status.full         = (r_count == CNT_DEPTH);
        w_status.empty        = (r_count == '0);
        w_status.almost_full  = (r_count >= CNT_AF);
        w_status.almost_empty = (r_count <= CNT_AE);
        w_status.overflow     = r_overflow;
        w_status.underflow    = r_underflow;
    end

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (i_data_in),
        .i_rd_en   (w_rd_ok),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (o_data_out)
    );

    assign o_read_valid   = r_read_valid;
    assign o_count        = r_count;
    assign o_full         = w_status.full;
    assign o_empty        = w_status.empty;
    assign o_almost_full  = w_status.almost_full;
    assign o_almost_empty = w_status.almost_empty;
    assign o_overflow     = w_status.overflow;
    assign o_underflow    = w_status.underflow;

endmodule : sync_fifo_core

// File: tb/tb_sync_fifo_core.sv
// Bench for sync_fifo_core. It runs directed scenarios and then random
// traffic. Every output is compared against a queue-based reference model.
module tb_sync_fifo_core;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          we  = 1'b0;
    logic [DW-1:0] din = '0;
    logic          re  = 1'b0;
    logic [DW-1:0] dout;
    logic          rvalid, full, empty, afull, aempty, ovf, udf;
    logic [AW:0]   cnt;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_rv, m_ovf, m_udf;

    always #5 clk = ~clk;

    sync_fifo_core #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_write_enable (we),
        .i_data_in      (din),
        .i_read_enable  (re),
        .o_data_out     (dout),
        .o_read_valid   (rvalid),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (afull),
        .o_almost_empty (aempty),
        .o_count        (cnt),
        .o_overflow     (ovf),
        .o_underflow    (udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ":count"},  32'(cnt),    32'(q.size()));
        chk({ctx, ":full"},   32'(full),   32'(q.size() == DEPTH));
        chk({ctx, ":empty"},  32'(empty),  32'(q.size() == 0));
        chk({ctx, ":afull"},  32'(afull),  32'(q.size() >= AF));
        chk({ctx, ":aempty"}, 32'(aempty), 32'(q.size() <= AE));
        chk({ctx, ":dout"},   32'(dout),   32'(m_dout));
        chk({ctx, ":rvalid"}, 32'(rvalid), 32'(m_rv));
        chk({ctx, ":ovf"},    32'(ovf),    32'(m_ovf));
        chk({ctx, ":udf"},    32'(udf),    32'(m_udf));
    endtask

    // One clock of traffic. The inputs are driven at the falling edge, and
    // the model follows the FIFO rules at the rising edge. The outputs are
    // then checked 1 time unit later.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input string ctx);
        bit rd_ok, wr_ok;
        @(negedge clk);
        we = w; din = d; re = r;
        @(posedge clk);
        rd_ok = r && (q.size() > 0);
        wr_ok = w && ((q.size() < DEPTH) || rd_ok);
        if (rd_ok) m_dout = q.pop_front();
        if (wr_ok) q.push_back(d);
        m_rv  = rd_ok;
        m_ovf = w && !wr_ok;
        m_udf = r && !rd_ok;
        #1;
        check_all(ctx);
    endtask

    task automatic do_reset(input string ctx);
        @(negedge clk);
        rst = 1'b1; we = 1'b0; re = 1'b0;
        @(posedge clk);
        q.delete();
        m_dout = '0; m_rv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        #1;
        check_all(ctx);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        m_dout = '0; m_rv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        do_reset("reset");

        // Fill with 0x11..0x18.
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h11 + i), 1'b0, "fill");
        chk("full_after_fill", 32'(full), 32'd1);

        // Writes while full are refused and flagged.
        step(1'b1, 8'hAA, 1'b0, "ovf1");
        step(1'b1, 8'hAA, 1'b0, "ovf2");
        chk("ovf_pulse", 32'(ovf), 32'd1);
        step(1'b0, 8'h00, 1'b0, "ovf_clear");

        // Drain in order, then one extra read.
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, "drain");
        chk("last_drained", 32'(dout), 32'h18);
        step(1'b0, 8'h00, 1'b1, "udf");
        chk("udf_pulse", 32'(udf), 32'd1);
        chk("udf_hold", 32'(dout), 32'h18);

        // Bursts of 3 writes and 3 reads, so the pointers wrap several times.
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + b * 3 + i), 1'b0, "wrap_w");
            for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, "wrap_r");
        end
        chk("wrap_count", 32'(cnt), 32'd0);

        // Simultaneous read and write while full.
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, "refill");
        step(1'b1, 8'h55, 1'b1, "full_rw");
        chk("full_rw_count", 32'(cnt), 32'd8);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, "drain2");
        chk("tail_55", 32'(dout), 32'h55);

        // Simultaneous read and write while empty: there is no bypass.
        step(1'b1, 8'h66, 1'b1, "empty_rw");
        chk("empty_rw_udf", 32'(udf), 32'd1);
        step(1'b0, 8'h00, 1'b1, "read_66");
        chk("read_66", 32'(dout), 32'h66);

        // Reset in the middle of traffic with 5 words stored.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h70 + i), 1'b0, "pre_rst");
        do_reset("mid_reset");
        step(1'b1, 8'h77, 1'b0, "post_rst_w");
        step(1'b0, 8'h00, 1'b1, "post_rst_r");
        chk("post_rst_data", 32'(dout), 32'h77);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_sync_fifo_core
